// File: rtl/clkdiv_multi.sv
// clkdiv_multi: multi-channel programmable clock divider.
//
// Each channel divides clk by 2*(active+1) and produces a 50% duty square wave
// plus a one-clock strobe in the cycle the square wave first reads 1. A new
// half-period can be loaded at any time. It is applied only on the next toggle
// edge, so a half-period already in progress always completes without a glitch.
//
// Ports
//   clk      in   system clock, rising-edge active
//   rst      in   asynchronous active-high reset
//   en       in   [CHANNELS] per-channel run enable
//   sync     in   global phase-align request; clears every channel while high
//   load     in   [CHANNELS] one-cycle request to capture a new half-period
//   div_cfg  in   [CHANNELS*COUNT_WIDTH] half-period values, channel i at
//                 [i*COUNT_WIDTH +: COUNT_WIDTH]
//   out      out  [CHANNELS] divided square waves (registered)
//   tick     out  [CHANNELS] rising-edge strobes (registered)
//   pend     out  [CHANNELS] a loaded half-period is waiting for the next toggle
module clkdiv_multi #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned COUNT_WIDTH = 8,
    parameter int unsigned RESET_HALF  = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CHANNELS-1:0]             en,
    input  logic                            sync,
    input  logic [CHANNELS-1:0]             load,
    input  logic [CHANNELS*COUNT_WIDTH-1:0] div_cfg,
    output logic [CHANNELS-1:0]             out,
    output logic [CHANNELS-1:0]             tick,
    output logic [CHANNELS-1:0]             pend
);

    localparam logic [COUNT_WIDTH-1:0] ResetHalf = COUNT_WIDTH'(RESET_HALF);
    localparam logic [COUNT_WIDTH-1:0] CntOne    = COUNT_WIDTH'(1);

    for (genvar i = 0; i < int'(CHANNELS); i++) begin : g_chan
        logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
        logic [COUNT_WIDTH-1:0] active_q, active_d;
        logic [COUNT_WIDTH-1:0] shadow_q, shadow_d;
        logic                   out_q, out_d;
        logic                   tick_q, tick_d;
        logic                   pend_q, pend_d;
        logic [COUNT_WIDTH-1:0] cfg;
        logic [COUNT_WIDTH-1:0] next_active;

        assign cfg = div_cfg[i*COUNT_WIDTH +: COUNT_WIDTH];

        // Value taken by active whenever an update is allowed: a load in the
        // same cycle beats an older pending one, which beats holding.
        assign next_active = load[i] ? cfg : (pend_q ? shadow_q : active_q);

        always_comb begin
            cnt_d    = cnt_q;
            active_d = active_q;
            shadow_d = shadow_q;
            out_d    = out_q;
            tick_d   = tick_q;
            pend_d   = pend_q;

            if (sync || !en[i]) begin
                // Idle/phase-align: no half-period is in progress, so any new
                // value can be applied straight away.
                cnt_d    = '0;
                out_d    = 1'b0;
                tick_d   = 1'b0;
                active_d = next_active;
                pend_d   = 1'b0;
            end else if (cnt_q != active_q) begin
                cnt_d  = cnt_q + CntOne;
                tick_d = 1'b0;
                if (load[i]) begin
                    shadow_d = cfg;
                    pend_d   = 1'b1;
                end
            end else begin
                // Toggle cycle: the half-period ends here, safe point to switch.
                cnt_d    = '0;
                out_d    = ~out_q;
                tick_d   = ~out_q;
                active_d = next_active;
                pend_d   = 1'b0;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q    <= '0;
                active_q <= ResetHalf;
                shadow_q <= ResetHalf;
                out_q    <= 1'b0;
                tick_q   <= 1'b0;
                pend_q   <= 1'b0;
            end else begin
                cnt_q    <= cnt_d;
                active_q <= active_d;
                shadow_q <= shadow_d;
                out_q    <= out_d;
                tick_q   <= tick_d;
                pend_q   <= pend_d;
            end
        end

        assign out[i]  = out_q;
        assign tick[i] = tick_q;
        assign pend[i] = pend_q;
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// tb_clkdiv_multi: directed self-checking bench for clkdiv_multi.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too,
// so each sample reflects the edge just taken. Waveforms over a window are
// packed into vectors (bit k = value after edge k) and compared against
// hand-computed patterns.
module tb_clkdiv_multi;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst;
    logic [1:0]   en;
    logic         sync;
    logic [1:0]   load;
    logic [2*W-1:0] div_cfg;
    logic [1:0]   out;
    logic [1:0]   tick;
    logic [1:0]   pend;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [31:0] v_out0, v_out1, v_tick0, v_tick1, v_pend0, v_pend1;

    clkdiv_multi #(
        .CHANNELS   (2),
        .COUNT_WIDTH(W),
        .RESET_HALF (5)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .sync   (sync),
        .load   (load),
        .div_cfg(div_cfg),
        .out    (out),
        .tick   (tick),
        .pend   (pend)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_vecs();
        v_out0 = '0; v_out1 = '0; v_tick0 = '0; v_tick1 = '0; v_pend0 = '0; v_pend1 = '0;
    endtask

    task automatic sample(input int k);
        v_out0[k]  = out[0];
        v_out1[k]  = out[1];
        v_tick0[k] = tick[0];
        v_tick1[k] = tick[1];
        v_pend0[k] = pend[0];
        v_pend1[k] = pend[1];
    endtask

    initial begin
        rst     = 1'b1;
        en      = 2'b11;
        sync    = 1'b0;
        load    = 2'b00;
        div_cfg = '0;

        // Reset defaults
        step();
        step();
        check("rst_out", {30'd0, out}, 32'd0);
        check("rst_tick", {30'd0, tick}, 32'd0);
        check("rst_pend", {30'd0, pend}, 32'd0);
        rst = 1'b0;
        clear_vecs();
        for (int k = 0; k < 24; k++) begin
            step();
            sample(k);
        end
        check("def_out0", v_out0, 32'h007E07E0);
        check("def_out1", v_out1, 32'h007E07E0);
        check("def_tick0", v_tick0, 32'h00020020);
        check("def_tick1", v_tick1, 32'h00020020);
        check("def_pend", v_pend0 | v_pend1, 32'd0);

        // Minimum divide: load 0 into ch0 while disabled, then enable
        en      = 2'b10;
        load    = 2'b01;
        div_cfg = {8'd0, 8'd0};
        step();
        check("min_pend_dis", {31'd0, pend[0]}, 32'd0);
        check("min_out_dis", {31'd0, out[0]}, 32'd0);
        load = 2'b00;
        en   = 2'b01;
        clear_vecs();
        for (int k = 0; k < 8; k++) begin
            step();
            sample(k);
        end
        check("min_out0", v_out0, 32'h55);
        check("min_tick0", v_tick0, 32'h55);

        // Mid-run update on ch1 (active 5): load 2 at cnt=2, then 4 and 3
        en = 2'b00;
        step();
        en = 2'b10;
        clear_vecs();
        for (int k = 0; k < 20; k++) begin
            load = 2'b00;
            if (k == 2)  begin load = 2'b10; div_cfg = {8'd2, 8'd0}; end
            if (k == 9)  begin load = 2'b10; div_cfg = {8'd4, 8'd0}; end
            if (k == 10) begin load = 2'b10; div_cfg = {8'd3, 8'd0}; end
            step();
            sample(k);
        end
        load = 2'b00;
        check("upd_out1", v_out1, 32'h000878E0);
        check("upd_tick1", v_tick1, 32'h00080820);
        check("upd_pend1", v_pend1, 32'h0000061C);

        // Load on the toggle cycle of ch1 (active 3)
        en = 2'b00;
        step();
        en = 2'b10;
        clear_vecs();
        for (int k = 0; k < 8; k++) begin
            load = 2'b00;
            if (k == 3) begin load = 2'b10; div_cfg = {8'd1, 8'd0}; end
            step();
            sample(k);
        end
        load = 2'b00;
        check("tog_out1", v_out1, 32'h98);
        check("tog_tick1", v_tick1, 32'h88);
        check("tog_pend1", v_pend1, 32'h0);

        // Enable/sync: ch0 active 2, ch1 active 4, started out of phase
        en      = 2'b00;
        load    = 2'b11;
        div_cfg = {8'd4, 8'd2};
        step();
        check("sy_load_pend", {30'd0, pend}, 32'd0);
        load = 2'b00;
        en   = 2'b01;
        for (int k = 0; k < 3; k++) step();
        en = 2'b11;
        for (int k = 0; k < 4; k++) step();
        sync = 1'b1;
        step();
        check("sy_out", {30'd0, out}, 32'd0);
        check("sy_tick", {30'd0, tick}, 32'd0);
        sync = 1'b0;
        clear_vecs();
        for (int k = 0; k < 32; k++) begin
            step();
            sample(k);
        end
        check("sy_out0", v_out0, 32'h1C71C71C);
        check("sy_out1", v_out1, 32'h1F07C1F0);
        check("sy_tick0", v_tick0, 32'h04104104);
        check("sy_tick1", v_tick1, 32'h01004010);
        step();
        check("en_out0_hi", {31'd0, out[0]}, 32'd1);
        en = 2'b10;
        step();
        check("en_out0_drop", {31'd0, out[0]}, 32'd0);

        // Async reset mid-run with out[1]=1 and pend[1]=1
        en = 2'b00;
        step();
        en = 2'b10;
        for (int k = 0; k < 5; k++) step();
        check("ar_out1_pre", {31'd0, out[1]}, 32'd1);
        load    = 2'b10;
        div_cfg = {8'd7, 8'd0};
        step();
        load = 2'b00;
        check("ar_pend1_pre", {31'd0, pend[1]}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("ar_out", {30'd0, out}, 32'd0);
        check("ar_tick", {30'd0, tick}, 32'd0);
        check("ar_pend", {30'd0, pend}, 32'd0);
        #2;
        rst = 1'b0;
        clear_vecs();
        for (int k = 0; k < 12; k++) begin
            step();
            sample(k);
        end
        check("ar_out1_post", v_out1, 32'h7E0);
        check("ar_tick1_post", v_tick1, 32'h20);
        check("ar_pend1_post", v_pend1, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
